traffic_sensor_conditioner: RTL and testbench
=============================================

# traffic_sensor_conditioner

Conditions the two raw car-presence inputs (Basys3 switches/buttons) into clean `Sa`/`Sb` requests for the traffic-light controller, which sits directly downstream. Each channel is synchronized, debounced and optionally held for a number of phase ticks after the car leaves, so a brief release does not drop the request mid-phase. It also emits a one-cycle arrival pulse per channel for counters or LEDs.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a new synchronized level must persist before it is accepted (10 ms at 100 MHz). Legal range is ≥1.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `HOLD_TICKS`, default 1: phase ticks a request stays asserted after the debounced input falls. 0 disables hold.
- `HOLD_W`, default 2: hold counter width. Must satisfy 2^HOLD_W > HOLD_TICKS.

Ports:
- `clock` in 1: single system clock. Every register is on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `rawSa` in 1: asynchronous raw sensor, street A.
- `rawSb` in 1: asynchronous raw sensor, street B.
- `tick` in 1: one-cycle pulse per controller phase step (3 s), synchronous to `clock`.
- `Sa` out 1: conditioned request, street A.
- `Sb` out 1: conditioned request, street B.
- `edgeSa` out 1: one-cycle pulse when A's debounced level rises.
- `edgeSb` out 1: one-cycle pulse when B's debounced level rises.

## Operation

The two channels are identical and fully independent. Each channel has the following registers: `sync1`, `sync2`, `stable`, `dbCnt[CNT_W]`, `holdCnt[HOLD_W]`, and the edge register.

- **Synchronizer:** two flops, raw → `sync1` → `sync2`. There is no other use of the raw input.
- **Debounce:**
  - If `sync2 == stable`, `dbCnt` clears to 0.
  - Else if `dbCnt == DEBOUNCE_CYCLES-1`, `stable` toggles and `dbCnt` clears to 0.
  - Else `dbCnt` increments.
  - Any return of `sync2` to `stable` before acceptance restarts the count from 0. There is no accumulation across glitches.
- **Edge pulse:** `edgeS` is registered. It is 1 for exactly the cycle after the edge on which `stable` goes 0→1. A 1→0 change produces no pulse.
- **Hold:**
  - While `stable==1`, `holdCnt` loads `HOLD_TICKS` every cycle.
  - While `stable==0`, `tick==1` and `holdCnt!=0`, `holdCnt` decrements.
  - Otherwise `holdCnt` keeps its value.
- **Output:** `S = stable | (holdCnt != 0)`. It is registered, i.e. computed from next-state values and stored in an output flop, so `S` is glitch-free.
- **Arithmetic:** all counters are unsigned. `dbCnt` never exceeds `DEBOUNCE_CYCLES-1`. `holdCnt` never wraps below 0.

## Timing

- **Reset:** on any edge with `reset==1`, all of the following go to 0: `sync1`, `sync2`, `stable`, `dbCnt`, `holdCnt`, `Sa`, `Sb`, `edgeSa`, `edgeSb`. Reset overrides `tick` and raw inputs in the same cycle.
- **Reset mid-operation:** an in-progress debounce count and any pending hold are discarded. After release, a raw input still high is re-qualified from scratch, with the full latency below.
- **Assertion latency:** raw rises and stays high from before edge N.
  - `stable` becomes 1 after edge N+DEBOUNCE_CYCLES+1.
  - `S` and `edgeS` become 1 after edge N+DEBOUNCE_CYCLES+2.
  - Total is DEBOUNCE_CYCLES+3 edges.
- **Release latency with HOLD_TICKS=0:** the same DEBOUNCE_CYCLES+3 edges after raw falls.
- **Release latency with HOLD_TICKS=H>0:** `S` stays 1 until the H-th `tick` seen while `stable==0`. `S` falls one edge after that tick.
  - A `tick` coincident with `stable`'s 1→0 edge does not count, because `stable` was still 1 on that edge and `holdCnt` reloads.
- **Re-assertion during hold:** `stable` returning to 1 reloads `holdCnt`. `S` never drops, and `edgeS` pulses again.
- **Ticks during assertion:** `tick` has no effect while `stable==1`. Consecutive `tick` pulses on adjacent cycles each decrement.
- **Simultaneous events:** both channels may toggle and pulse on the same cycle with no interaction.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, HOLD_TICKS=2, `tick` every 10 cycles unless noted.

1. **Reset behaviour.** Hold `reset=1` for 3 cycles with `rawSa=rawSb=1` and `tick` toggling. Required: all outputs 0 throughout. After release, `Sa` and `Sb` assert exactly 7 edges later.
2. **Glitch rejection.**
   - `rawSa=1` for 3 cycles, then 0. Required: `Sa` and `edgeSa` never assert.
   - Repeat with 3-high / 1-low / 3-high. Required: still no assertion, because the count restarts.
3. **Clean press.** `rawSa` 0→1 held before edge N. Required: `Sa=1` after edge N+6, and `edgeSa=1` for exactly that one cycle.
4. **Hold across release.** From `Sa=1`, drop `rawSa`. Required: `Sa` stays 1 until one edge after the 2nd `tick` following `stable` falling. With HOLD_TICKS=0 rerun, required: `Sa` falls 7 edges after release.
5. **Re-press during hold.** Re-raise `rawSa` after the 1st tick. Required: `Sa` never deasserts, and `edgeSa` pulses once more.
6. **Independence and mid-debounce reset.**
   - Toggle `rawSa` and `rawSb` on the same edge. Required: identical, simultaneous `Sa`/`Sb`/`edge` waveforms.
   - Assert `reset` at `dbCnt=2`. Required: the count is discarded, and the full 7-edge latency applies after release.

Source files
------------

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: turns two raw car-presence inputs into clean,
// glitch-free Sa/Sb requests for the traffic-light controller, with an
// optional post-release hold measured in phase ticks and a one-cycle
// arrival pulse per street.

// One conditioning channel: synchronizer, debouncer, tick-based hold, edge pulse.
module traffic_sensor_channel #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int HOLD_TICKS      = 1,
  parameter int HOLD_W          = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic req,
  output logic rise
);

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  logic              sync1;
  logic              sync2;
  logic              stable;
  logic              stable_p1;
  logic [CNT_W-1:0]  dbCnt;
  logic [HOLD_W-1:0] holdCnt;

  // Synchronize, debounce, hold and register the request and rise pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      stable    <= 1'b0;
      stable_p1 <= 1'b0;
      dbCnt     <= '0;
      holdCnt   <= '0;
      req       <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      stable_p1 <= stable;

      // A new level must persist DEBOUNCE_CYCLES consecutive cycles; any
      // return to the accepted level restarts the count from zero.
      if (sync2 == stable) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_LAST) begin
        stable <= ~stable;
        dbCnt  <= '0;
      end else begin
        dbCnt <= dbCnt + CNT_W'(1);
      end

      // Hold is armed while the car is present and drains only on ticks
      // after it leaves, never wrapping below zero.
      if (stable) begin
        holdCnt <= HOLD_LOAD;
      end else if (tick && (holdCnt != '0)) begin
        holdCnt <= holdCnt - HOLD_W'(1);
      end

      req  <= stable | (holdCnt != '0);
      rise <= stable & ~stable_p1;
    end
  end

endmodule

// Two identical, independent channels for streets A and B.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int HOLD_TICKS      = 1,
  parameter int HOLD_W          = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic rawSa,
  input  logic rawSb,
  input  logic tick,
  output logic Sa,
  output logic Sb,
  output logic edgeSa,
  output logic edgeSb
);

  traffic_sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .HOLD_TICKS     (HOLD_TICKS),
    .HOLD_W         (HOLD_W)
  ) chanA (
    .clock(clock),
    .reset(reset),
    .raw  (rawSa),
    .tick (tick),
    .req  (Sa),
    .rise (edgeSa)
  );

  traffic_sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .HOLD_TICKS     (HOLD_TICKS),
    .HOLD_W         (HOLD_W)
  ) chanB (
    .clock(clock),
    .reset(reset),
    .raw  (rawSb),
    .tick (tick),
    .req  (Sb),
    .rise (edgeSb)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench for traffic_sensor_conditioner. Each scenario is a set of
// per-cycle strings: inputs applied before edge i, expected outputs after
// edge i. A second instance with HOLD_TICKS=0 shares all inputs.
module tb_traffic_sensor_conditioner;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rawSa = 1'b0;
  logic rawSb = 1'b0;
  logic tick  = 1'b0;
  logic Sa, Sb, edgeSa, edgeSb;
  logic Sa0, Sb0, edgeSa0, edgeSb0;

  always #5 clock = ~clock;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4), .CNT_W(2), .HOLD_TICKS(2), .HOLD_W(2)
  ) dut (
    .clock(clock), .reset(reset), .rawSa(rawSa), .rawSb(rawSb), .tick(tick),
    .Sa(Sa), .Sb(Sb), .edgeSa(edgeSa), .edgeSb(edgeSb)
  );

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4), .CNT_W(2), .HOLD_TICKS(0), .HOLD_W(2)
  ) dut0 (
    .clock(clock), .reset(reset), .rawSa(rawSa), .rawSb(rawSb), .tick(tick),
    .Sa(Sa0), .Sb(Sb0), .edgeSa(edgeSa0), .edgeSb(edgeSb0)
  );

  typedef struct {
    logic [5:0] exp;
    logic [5:0] msk;
    int         scen;
    int         cyc;
  } exp_t;

  exp_t  sbq[$];
  int    passed = 0;
  int    total  = 0;
  string names[6] = '{"Sa", "Sb", "edgeSa", "edgeSb", "Sa_hold0", "Sb_hold0"};

  // '1' for a <= i <= b, else '0'
  function automatic string rng(int n, int a, int b);
    string r = "";
    string one = "1";
    string zero = "0";
    for (int i = 0; i < n; i++) r = {r, ((i >= a && i <= b) ? one : zero)};
    return r;
  endfunction

  // '1' at p0, p0+per, p0+2*per, ...
  function automatic string pulse(int n, int p0, int per);
    string r = "";
    string one = "1";
    string zero = "0";
    for (int i = 0; i < n; i++)
      r = {r, ((i >= p0 && ((i - p0) % per) == 0) ? one : zero)};
    return r;
  endfunction

  function automatic string or2(string x, string y);
    string r = x;
    for (int i = 0; i < x.len(); i++)
      if (y[i] == "1") r[i] = "1";
    return r;
  endfunction

  function automatic string zeros(int n);
    return rng(n, 1, 0);
  endfunction

  task automatic run(input int scen, input string rs, input string ra,
                     input string rb, input string tk,
                     input string xSa, input string xSb,
                     input string xEa, input string xEb,
                     input string xSa0, input string xSb0);
    string xs[6];
    exp_t  e;
    xs = '{xSa, xSb, xEa, xEb, xSa0, xSb0};
    for (int i = 0; i < rs.len(); i++) begin
      @(negedge clock);
      reset = (rs[i] == "1");
      rawSa = (ra[i] == "1");
      rawSb = (rb[i] == "1");
      tick  = (tk[i] == "1");
      @(posedge clock);
      e.exp  = '0;
      e.msk  = '0;
      e.scen = scen;
      e.cyc  = i;
      for (int f = 0; f < 6; f++) begin
        if (xs[f].len() > i && xs[f][i] != ".") begin
          e.msk[f] = 1'b1;
          e.exp[f] = (xs[f][i] == "1");
        end
      end
      sbq.push_back(e);
    end
  endtask

  exp_t       cur;
  logic [5:0] act;

  // Monitor: compare each queued expectation against the outputs just after the edge.
  always @(posedge clock) begin
    #1;
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      act = {Sb0, Sa0, edgeSb, edgeSa, Sb, Sa};
      for (int f = 0; f < 6; f++) begin
        if (cur.msk[f]) begin
          total++;
          if (act[f] === cur.exp[f]) passed++;
          else $display("FAIL %s scen %0d cycle %0d: got %b want %b",
                        names[f], cur.scen, cur.cyc, act[f], cur.exp[f]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held 3 cycles with raw high and tick toggling; 7-edge latency after release
    run(1, rng(12, 0, 2), rng(12, 0, 11), rng(12, 0, 11), pulse(12, 0, 2),
        rng(12, 9, 11), rng(12, 9, 11), rng(12, 9, 9), rng(12, 9, 9),
        rng(12, 9, 11), rng(12, 9, 11));

    // 2a: 3-cycle glitch on A is rejected
    run(2, rng(12, 0, 0), rng(12, 1, 3), zeros(12), pulse(12, 5, 10),
        zeros(12), zeros(12), zeros(12), zeros(12), zeros(12), zeros(12));

    // 2b: 3 high / 1 low / 3 high still rejected (count restarts)
    run(3, rng(16, 0, 0), or2(rng(16, 1, 3), rng(16, 5, 7)), zeros(16), zeros(16),
        zeros(16), zeros(16), zeros(16), zeros(16), zeros(16), zeros(16));

    // 3/4/6a: clean press on both streets, release, tick during assertion,
    // tick coincident with stable falling, then two counted ticks
    run(4, rng(32, 0, 0), rng(32, 2, 13), rng(32, 2, 13),
        or2(or2(rng(32, 10, 10), rng(32, 19, 19)), pulse(32, 24, 5)),
        rng(32, 8, 29), rng(32, 8, 29), rng(32, 8, 8), rng(32, 8, 8),
        rng(32, 8, 19), rng(32, 8, 19));

    // 5: re-press A after the first hold tick while B only glitches
    run(5, rng(40, 0, 0), or2(rng(40, 2, 13), rng(40, 25, 39)),
        or2(rng(40, 1, 3), rng(40, 5, 7)), pulse(40, 4, 10),
        rng(40, 8, 39), zeros(40), or2(rng(40, 8, 8), rng(40, 31, 31)), zeros(40),
        or2(rng(40, 8, 19), rng(40, 31, 39)), zeros(40));

    // 6b: reset while dbCnt==2 discards the count; full latency after release
    run(6, or2(rng(16, 0, 0), rng(16, 5, 5)), rng(16, 1, 15), zeros(16), zeros(16),
        rng(16, 12, 15), zeros(16), rng(16, 12, 12), zeros(16),
        rng(16, 12, 15), zeros(16));

    // 7: ticks on adjacent cycles each decrement the hold
    run(7, rng(28, 0, 0), rng(28, 2, 13), zeros(28), rng(28, 22, 23),
        rng(28, 8, 23), zeros(28), rng(28, 8, 8), zeros(28),
        rng(28, 8, 19), zeros(28));

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clock);
    #2;
    if (sbq.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending entries want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
